// File: rtl/seq_alu.sv
// Multi-cycle ALU (ADD/SUB/iterative SHL/shift-add MUL) with valid/ready handshakes.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 11 returns err=1.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpShl = 2'b10;
  localparam logic [1:0] OpMul = 2'b11;

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WidthW = WIDTH[WIDTH-1:0];

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             shc_q, shc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;

  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  // Bit WIDTH of the extended difference is the borrow (a < b).
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mac_sum;

  // Right-shifting accumulator: low half starts as the multiplier and drains out.
  assign mac_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    shc_d    = shc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
`endif

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = opcode;
          a_d     = a;
          b_d     = b;
          shc_d   = 1'b0;
          state_d = StBusy;
          case (opcode)
            OpShl:   cnt_d = (b >= WidthW) ? CntW'(WIDTH) : CntW'(b);
`ifdef ALU_MUL_EN
            OpMul: begin
              cnt_d = CntW'(WIDTH);
              acc_d = {{WIDTH{1'b0}}, b};
            end
`endif
            default: cnt_d = '0;
          endcase
        end
      end

      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (op_q == OpShl) begin
            shc_d = a_q[WIDTH-1];
            a_d   = a_q << 1;
          end
`ifdef ALU_MUL_EN
          else begin
            acc_d = {mac_sum, acc_q[WIDTH-1:1]};
          end
`endif
        end else begin
          state_d = StDone;
          err_d   = 1'b0;
          unique case (op_q)
            OpAdd: begin
              result_d = add_w[WIDTH-1:0];
              carry_d  = add_w[WIDTH];
            end
            OpSub: begin
              result_d = sub_w[WIDTH-1:0];
              carry_d  = sub_w[WIDTH];
            end
            OpShl: begin
              result_d = a_q;
              carry_d  = shc_q;
            end
            OpMul: begin
`ifdef ALU_MUL_EN
              result_d = acc_q[WIDTH-1:0];
              carry_d  = |acc_q[2*WIDTH-1:WIDTH];
`else
              result_d = '0;
              carry_d  = 1'b0;
              err_d    = 1'b1;
`endif
            end
          endcase
          zero_d = (result_d == '0);
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      shc_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      shc_q    <= shc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed spec vectors, random ops against
// an arithmetic reference model, backpressure and mid-operation reset.
module tb_seq_alu;
  localparam int unsigned W = 8;
`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   opcode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, zero, err;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_bad = 0;
  int n_acc = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         e;
  } vec_t;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) n_acc++;
  end

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] av,
                                input logic [W-1:0] bv, output int lat,
                                output logic [W-1:0] r, output logic c,
                                output logic z, output logic e);
    int     s;
    int     sh;
    longint t;
    e   = 1'b0;
    lat = 1;
    case (op)
      2'b00: begin
        s = int'(av) + int'(bv);
        r = W'(s % 256);
        c = (s > 255);
      end
      2'b01: begin
        s = int'(av) - int'(bv);
        r = W'((s + 256) % 256);
        c = (s < 0);
      end
      2'b10: begin
        sh  = (int'(bv) >= int'(W)) ? int'(W) : int'(bv);
        t   = longint'(av) << sh;
        r   = W'(t);
        c   = t[W];
        lat = 1 + sh;
      end
      default: begin
        if (MulEn) begin
          s   = int'(av) * int'(bv);
          r   = W'(s);
          c   = ((s >> W) != 0);
          lat = W + 1;
        end else begin
          r = '0;
          c = 1'b0;
          e = 1'b1;
        end
      end
    endcase
    z = (r == '0);
  endfunction

  // Issue one op (starting in IDLE, #1 after an edge) and capture the result bundle.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output logic [W-1:0] r, output logic c,
                       output logic z, output logic e);
    opcode   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode   = 2'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
    lat      = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 64);
    if (!out_valid) lat = -1;
    r = result;
    c = carry;
    z = zero;
    e = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    repeat (2) @(posedge clk);
    #1;
    n_vec += 6;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 00", result); end
    if (carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b want 0", carry); end
    if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b want 0", zero); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t         tbl[5];
    int           lat;
    logic [W-1:0] r;
    logic         c, z, e;
    tbl[0] = '{2'b00, 8'h80, 8'h80, 1, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{2'b01, 8'h01, 8'h02, 1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 8'hC1, 8'h03, 4, 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'b10, 8'hC1, 8'h09, 9, 8'h00, 1'b1, 1'b1, 1'b0};
    if (MulEn) tbl[4] = '{2'b11, 8'h1F, 8'h11, 9, 8'h0F, 1'b1, 1'b0, 1'b0};
    else       tbl[4] = '{2'b11, 8'h1F, 8'h11, 1, 8'h00, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, r, c, z, e);
      n_vec += 5;
      if (lat != tbl[i].lat) begin
        n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].lat);
      end
      if (r !== tbl[i].r) begin
        n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, r, tbl[i].r);
      end
      if (c !== tbl[i].c) begin
        n_bad++; $display("FAIL dir%0d_carry: got %b want %b", i, c, tbl[i].c);
      end
      if (z !== tbl[i].z) begin
        n_bad++; $display("FAIL dir%0d_zero: got %b want %b", i, z, tbl[i].z);
      end
      if (e !== tbl[i].e) begin
        n_bad++; $display("FAIL dir%0d_err: got %b want %b", i, e, tbl[i].e);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] av, bv, r, er;
    logic         c, z, e, ec, ez, ee;
    int           lat, elat;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      av = W'($urandom);
      bv = W'($urandom);
      if (op == 2'b10) bv = W'($urandom_range(0, 11));
      model(op, av, bv, elat, er, ec, ez, ee);
      do_op(op, av, bv, lat, r, c, z, e);
      n_vec += 5;
      if (lat != elat) begin
        n_bad++; $display("FAIL rnd%0d_latency op=%0d a=%h b=%h: got %0d want %0d",
                          i, op, av, bv, lat, elat);
      end
      if (r !== er) begin
        n_bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h",
                          i, op, av, bv, r, er);
      end
      if (c !== ec) begin
        n_bad++; $display("FAIL rnd%0d_carry op=%0d a=%h b=%h: got %b want %b",
                          i, op, av, bv, c, ec);
      end
      if (z !== ez) begin
        n_bad++; $display("FAIL rnd%0d_zero op=%0d a=%h b=%h: got %b want %b",
                          i, op, av, bv, z, ez);
      end
      if (e !== ee) begin
        n_bad++; $display("FAIL rnd%0d_err op=%0d a=%h b=%h: got %b want %b",
                          i, op, av, bv, e, ee);
      end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    int lat;
    n0        = n_acc;
    out_ready = 1'b0;
    opcode    = 2'b00;
    a         = 8'h0F;
    b         = 8'h01;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 16);
    n_vec++;
    if (lat != 1) begin n_bad++; $display("FAIL bp_latency: got %0d want 1", lat); end
    for (int k = 0; k < 3; k++) begin
      n_vec += 3;
      if (out_valid !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold%0d_out_valid: got %b want 1", k, out_valid);
      end
      if (result !== 8'h10) begin
        n_bad++; $display("FAIL bp_hold%0d_result: got %h want 10", k, result);
      end
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d_in_ready: got %b want 0", k, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    n_vec += 3;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    if (n_acc - n0 != 1) begin n_bad++; $display("FAIL bp_accepts: got %0d want 1", n_acc - n0); end
  endtask

  task automatic test_reset_midop();
    int           seen;
    int           lat;
    logic [W-1:0] r;
    logic         c, z, e;
    opcode   = 2'b11;
    a        = 8'h1F;
    b        = 8'h11;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec += 6;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    if (result !== '0) begin n_bad++; $display("FAIL midrst_result: got %h want 00", result); end
    if (carry !== 1'b0) begin n_bad++; $display("FAIL midrst_carry: got %b want 0", carry); end
    if (zero !== 1'b0) begin n_bad++; $display("FAIL midrst_zero: got %b want 0", zero); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", err); end
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_bad++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
    do_op(2'b00, 8'h05, 8'h03, lat, r, c, z, e);
    n_vec += 2;
    if (lat != 1) begin n_bad++; $display("FAIL midrst_recover_latency: got %0d want 1", lat); end
    if (r !== 8'h08) begin n_bad++; $display("FAIL midrst_recover_result: got %h want 08", r); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
